// File: rtl/row_feeder.sv
// -----------------------------------------------------------------------------
// row_feeder
//   Upstream stage of row_crossbar. This block works on one tile at a time:
//     1. It captures one tile of matrix-A columns into a local buffer.
//        Each column carries one element per array row.
//     2. It replays the buffered columns into the skew stage, one column per
//        cycle.
//     3. It appends ARRAY_HEIGHT-1 zero columns so the deepest skew lane
//        drains completely.
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   asynchronous, active-high reset
//   start           in   begin a tile (sampled only in IDLE)
//   k_len           in   number of columns in the tile, valid with start
//   abort           in   synchronous cancel of the current tile
//   in_valid        in   load beat valid
//   in_ready        out  load beat accepted when in_valid && in_ready
//   in_data         in   one column; lane r = bits [r*DATA_WIDTH +: DATA_WIDTH]
//   skew_sync_reset out  to row_crossbar.sync_reset (first LOAD cycle)
//   skew_shift      out  to row_crossbar.shift
//   skew_data       out  to row_crossbar.data_i
//   busy            out  high in any state but IDLE
//   done            out  1-cycle pulse, tile fully drained
//   err             out  1-cycle pulse, illegal k_len on start
//   dbg_state       out  current FSM state (IDLE=0, LOAD=1, STREAM=2, FLUSH=3)
//
// Handshake: a load beat transfers on a rising edge where in_valid and
// in_ready are both high. in_ready depends only on state. in_data must be
// stable while in_valid is high.
// -----------------------------------------------------------------------------
module row_feeder #(
  parameter int DATA_WIDTH   = 8,
  parameter int ARRAY_HEIGHT = 4,
  parameter int K_MAX        = 16,
  localparam int K_W         = $clog2(K_MAX + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [K_W-1:0]                     k_len,
  input  logic                               abort,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [ARRAY_HEIGHT*DATA_WIDTH-1:0] in_data,
  output logic                               skew_sync_reset,
  output logic                               skew_shift,
  output logic [ARRAY_HEIGHT*DATA_WIDTH-1:0] skew_data,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic [1:0]                         dbg_state
);

  localparam int COL_W = ARRAY_HEIGHT * DATA_WIDTH;
  localparam int AW    = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int FL_W  = (ARRAY_HEIGHT > 2) ? $clog2(ARRAY_HEIGHT - 1) : 1;
  localparam logic [FL_W-1:0] FL_LAST = FL_W'((ARRAY_HEIGHT > 1) ? ARRAY_HEIGHT - 2 : 0);
  localparam logic [K_W-1:0]  K_MAX_V = K_W'(K_MAX);
  localparam logic [K_W-1:0]  K_ONE   = K_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_FLUSH  = 2'd3
  } state_t;

  state_t           r_state;
  logic [K_W-1:0]   r_k_len;
  logic [K_W-1:0]   r_wr_ptr;
  logic [K_W-1:0]   r_rd_ptr;
  logic [FL_W-1:0]  r_fl_cnt;
  logic             r_sync_reset;
  logic             r_shift;
  logic [COL_W-1:0] r_data;
  logic             r_done;
  logic             r_err;
  logic [COL_W-1:0] r_buf [K_MAX];

  state_t           w_state_d;
  logic [K_W-1:0]   w_k_len_d;
  logic [K_W-1:0]   w_wr_ptr_d;
  logic [K_W-1:0]   w_rd_ptr_d;
  logic [FL_W-1:0]  w_fl_cnt_d;
  logic             w_sync_reset_d;
  logic             w_shift_d;
  logic [COL_W-1:0] w_data_d;
  logic             w_done_d;
  logic             w_err_d;
  logic             w_wr_en;
  logic             w_abort;
  logic             w_k_legal;
  logic [K_W-1:0]   w_last_idx;
  logic [AW-1:0]    w_wr_addr;
  logic [AW-1:0]    w_rd_addr;

  assign w_last_idx = r_k_len - K_ONE;
  assign w_wr_addr  = r_wr_ptr[AW-1:0];
  assign w_rd_addr  = r_rd_ptr[AW-1:0];
  assign w_k_legal  = (k_len != '0) && (k_len <= K_MAX_V);
  assign w_abort    = abort && (r_state != S_IDLE);

  always_comb begin
    w_state_d      = r_state;
    w_k_len_d      = r_k_len;
    w_wr_ptr_d     = r_wr_ptr;
    w_rd_ptr_d     = r_rd_ptr;
    w_fl_cnt_d     = r_fl_cnt;
    w_sync_reset_d = 1'b0;
    w_shift_d      = 1'b0;
    w_data_d       = '0;
    w_err_d        = 1'b0;
    w_wr_en        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_k_legal) begin
            w_k_len_d      = k_len;
            w_wr_ptr_d     = '0;
            w_sync_reset_d = 1'b1;
            w_state_d      = S_LOAD;
          end else begin
            w_err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          w_wr_en = 1'b1;
          if (r_wr_ptr == w_last_idx) begin
            w_rd_ptr_d = '0;
            w_state_d  = S_STREAM;
          end else begin
            w_wr_ptr_d = r_wr_ptr + K_ONE;
          end
        end
      end
      S_STREAM: begin
        w_shift_d = 1'b1;
        w_data_d  = r_buf[w_rd_addr];
        if (r_rd_ptr == w_last_idx) begin
          // A single-row array has no skew to drain, so go straight home.
          if (ARRAY_HEIGHT > 1) begin
            w_fl_cnt_d = '0;
            w_state_d  = S_FLUSH;
          end else begin
            w_state_d = S_IDLE;
          end
        end else begin
          w_rd_ptr_d = r_rd_ptr + K_ONE;
        end
      end
      S_FLUSH: begin
        w_shift_d = 1'b1;
        if (r_fl_cnt == FL_LAST) begin
          w_state_d = S_IDLE;
        end else begin
          w_fl_cnt_d = r_fl_cnt + FL_W'(1);
        end
      end
      default: w_state_d = S_IDLE;
    endcase

    if (w_abort) begin
      w_state_d = S_IDLE;
      w_shift_d = 1'b0;
      w_data_d  = '0;
      w_wr_en   = 1'b0;
    end

    // done marks the cycle right after the last shift, unless the tile was cut short.
    w_done_d = r_shift && !w_shift_d && !w_abort;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_k_len      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fl_cnt     <= '0;
      r_sync_reset <= 1'b0;
      r_shift      <= 1'b0;
      r_data       <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_k_len      <= w_k_len_d;
      r_wr_ptr     <= w_wr_ptr_d;
      r_rd_ptr     <= w_rd_ptr_d;
      r_fl_cnt     <= w_fl_cnt_d;
      r_sync_reset <= w_sync_reset_d;
      r_shift      <= w_shift_d;
      r_data       <= w_data_d;
      r_done       <= w_done_d;
      r_err        <= w_err_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_buf[w_wr_addr] <= in_data;
    end
  end

  assign in_ready        = (r_state == S_LOAD);
  assign busy            = (r_state != S_IDLE);
  assign skew_sync_reset = r_sync_reset;
  assign skew_shift      = r_shift;
  assign skew_data       = r_data;
  assign done            = r_done;
  assign err             = r_err;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_row_feeder.sv
// -----------------------------------------------------------------------------
// tb_row_feeder
//   Directed bench for row_feeder with default parameters.
//   Stimulus and checks share one clock discipline: inputs are driven on the
//   falling edge, and outputs are sampled on the falling edge.
//   The expected skew columns are kept in exp_q.
// -----------------------------------------------------------------------------
module tb_row_feeder;

  localparam int H   = 4;
  localparam int K_W = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [K_W-1:0] k_len;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          skew_sync_reset;
  logic          skew_shift;
  logic [31:0]   skew_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    dbg_state;

  logic [31:0]   exp_q[$];
  int            n_vec = 0;
  int            n_mis = 0;

  // clock / reset
  always #5 clk = ~clk;

  row_feeder dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .k_len           (k_len),
    .abort           (abort),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .skew_sync_reset (skew_sync_reset),
    .skew_shift      (skew_shift),
    .skew_data       (skew_data),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .dbg_state       (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // driver: pulse start for one cycle, optionally together with abort
  task automatic do_start(input int k, input bit with_abort);
    start = 1'b1;
    k_len = K_W'(k);
    abort = with_abort;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("sync_reset_first_load", skew_sync_reset, 1'b1);
    check("busy_in_load", busy, 1'b1);
    check("ready_in_load", in_ready, 1'b1);
  endtask

  // driver: k beats, 'stalls' idle cycles before every beat but the first
  task automatic load_tile(input int k, input int stalls, input logic [31:0] base);
    logic [31:0] col;
    for (int i = 0; i < k; i++) begin
      if (i > 0) begin
        for (int s = 0; s < stalls; s++) begin
          in_valid = 1'b0;
          step();
          check("ready_during_stall", in_ready, 1'b1);
        end
      end
      col      = base + i * 32'h04040404;
      in_data  = col;
      in_valid = 1'b1;
      exp_q.push_back(col);
      step();
      if (i < k - 1) begin
        check("ready_mid_load", in_ready, 1'b1);
        check("sync_reset_low", skew_sync_reset, 1'b0);
      end
    end
    in_valid = 1'b0;
    check("ready_drop_after_last", in_ready, 1'b0);
    for (int z = 0; z < H - 1; z++) exp_q.push_back(32'h0);
  endtask

  // scoreboard: the next n cycles must shift out exp_q, then done pulses once
  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("shift_high", skew_shift, 1'b1);
      check("skew_col", skew_data, exp_q.pop_front());
      check("no_early_done", done, 1'b0);
    end
    step();
    check("shift_low_after", skew_shift, 1'b0);
    check("done_pulse", done, 1'b1);
    check("idle_at_done", busy, 1'b0);
    step();
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    k_len    = '0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    step();
    step();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_shift", skew_shift, 1'b0);
    check("rst_data", skew_data, 32'h0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_sync_reset", skew_sync_reset, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    reset = 1'b0;
    step();

    // 1: nominal k_len=3, back-to-back beats
    do_start(3, 1'b0);
    load_tile(3, 0, 32'h04030201);
    collect(3 + H - 1);

    // 2: stalled load, in_valid 1,0,0,1,...
    do_start(4, 1'b0);
    load_tile(4, 2, 32'h11223344);
    collect(4 + H - 1);

    // 3: full-depth tile, then illegal lengths
    do_start(16, 1'b0);
    load_tile(16, 0, $urandom_range(32'h7fffffff, 0));
    collect(16 + H - 1);

    start = 1'b1;
    k_len = 5'd0;
    step();
    start = 1'b0;
    check("err_k0", err, 1'b1);
    check("busy_k0", busy, 1'b0);
    check("sync_reset_k0", skew_sync_reset, 1'b0);
    step();
    check("err_k0_pulse", err, 1'b0);

    start = 1'b1;
    k_len = 5'd17;
    step();
    start = 1'b0;
    check("err_k17", err, 1'b1);
    check("busy_k17", busy, 1'b0);
    check("sync_reset_k17", skew_sync_reset, 1'b0);
    step();
    check("err_k17_pulse", err, 1'b0);

    // 4: abort on the second STREAM cycle of a k_len=5 tile
    do_start(5, 1'b0);
    load_tile(5, 0, 32'hA0B0C0D0);
    step();
    check("abort_pre_shift", skew_shift, 1'b1);
    check("abort_pre_col", skew_data, exp_q.pop_front());
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_shift_low", skew_shift, 1'b0);
    check("abort_data_zero", skew_data, 32'h0);
    check("abort_idle", busy, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_done", done, 1'b0);
    end
    // start wins over a simultaneous abort in IDLE
    do_start(1, 1'b1);
    load_tile(1, 0, 32'hDEADBEEF);
    collect(1 + H - 1);

    // 5a: start while busy is ignored
    do_start(2, 1'b0);
    start    = 1'b1;
    k_len    = 5'd7;
    in_data  = 32'h55667788;
    in_valid = 1'b1;
    exp_q.push_back(32'h55667788);
    step();
    start = 1'b0;
    check("busy_start_no_err", err, 1'b0);
    check("busy_start_no_sync", skew_sync_reset, 1'b0);
    in_data = 32'h99AABBCC;
    exp_q.push_back(32'h99AABBCC);
    step();
    in_valid = 1'b0;
    check("busy_start_ready_drop", in_ready, 1'b0);
    for (int z = 0; z < H - 1; z++) exp_q.push_back(32'h0);
    collect(2 + H - 1);

    // 5b: async reset in the middle of FLUSH
    do_start(1, 1'b0);
    load_tile(1, 0, 32'h0F0E0D0C);
    step();
    check("pre_rst_col", skew_data, exp_q.pop_front());
    step();
    check("pre_rst_flush", skew_shift, 1'b1);
    check("pre_rst_state", dbg_state, 2'd3);
    #2 reset = 1'b1;
    #1;
    check("async_rst_shift", skew_shift, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_ready", in_ready, 1'b0);
    check("async_rst_data", skew_data, 32'h0);
    exp_q.delete();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_done", done, 1'b0);
      check("post_rst_no_err", err, 1'b0);
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
